// File: rtl/set_assoc_cache.sv
// Two-way set-associative, write-through, no-write-allocate cache with one LRU bit per set
// and saturating read-hit/read-miss counters.
module set_assoc_cache #(
  parameter int unsigned ADDR_W     = 18,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned SET_BITS   = 6,
  parameter int unsigned LINE_WORDS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cpu_rd_en,
  input  logic                         cpu_wr_en,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [DATA_W-1:0]            cpu_wdata,
  output logic [DATA_W-1:0]            cpu_rdata,
  output logic                         cpu_ready,
  input  logic                         flush,
  output logic                         mem_rd_req,
  output logic                         mem_wr_req,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W*LINE_WORDS-1:0] mem_rdata,
  input  logic                         mem_ready,
  output logic [15:0]                  hit_cnt,
  output logic [15:0]                  miss_cnt
);

  localparam int unsigned WOFF       = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 0;
  localparam int unsigned WOFF_W     = (WOFF > 0) ? WOFF : 1;
  localparam int unsigned SETS       = 1 << SET_BITS;
  localparam int unsigned TAG_W      = ADDR_W - 2 - WOFF - SET_BITS;
  localparam int unsigned LINE_BYTES = 4 * LINE_WORDS;

  typedef enum logic [1:0] {StIdle, StFill, StWthru} state_e;

  state_e              state_q;
  logic [SETS-1:0]     valid_q [2];
  logic [SETS-1:0]     lru_q;
  logic [TAG_W-1:0]    tag_q   [2][SETS];
  logic [DATA_W-1:0]   data_q  [2][SETS][LINE_WORDS];
  logic [15:0]         hit_cnt_q, miss_cnt_q;

  logic [SET_BITS-1:0] set_idx;
  logic [TAG_W-1:0]    tag;
  logic [WOFF_W-1:0]   woff;
  logic [ADDR_W-1:0]   line_addr;
  logic                hit0, hit1, hit, hit_way, victim;
  logic [DATA_W-1:0]   hit_word;
  logic [DATA_W-1:0]   fill_words [LINE_WORDS];
  logic                wr_hit, fill_done;
  logic                unused_byte_bits;

  assign set_idx          = cpu_addr[2+WOFF +: SET_BITS];
  assign tag              = cpu_addr[ADDR_W-1 -: TAG_W];
  assign line_addr        = cpu_addr & ~ADDR_W'(LINE_BYTES - 1);
  assign unused_byte_bits = ^cpu_addr[1:0];

  if (WOFF > 0) begin : g_woff
    assign woff = cpu_addr[2 +: WOFF_W];
  end else begin : g_no_woff
    assign woff = '0;
  end

  for (genvar i = 0; i < LINE_WORDS; i++) begin : g_fill_words
    assign fill_words[i] = mem_rdata[i*DATA_W +: DATA_W];
  end

  assign hit0     = valid_q[0][set_idx] && (tag_q[0][set_idx] == tag);
  assign hit1     = valid_q[1][set_idx] && (tag_q[1][set_idx] == tag);
  assign hit      = hit0 | hit1;
  assign hit_way  = hit1;
  assign hit_word = hit1 ? data_q[1][set_idx][woff] : data_q[0][set_idx][woff];

  // Invalid ways fill first (way0 before way1); otherwise lru=1 names way0, lru=0 names way1.
  assign victim = valid_q[0][set_idx] & (~valid_q[1][set_idx] | ~lru_q[set_idx]);

  assign wr_hit    = (state_q == StIdle) && !flush && cpu_wr_en && hit;
  assign fill_done = (state_q == StFill) && mem_ready;

  always_comb begin
    cpu_ready  = 1'b0;
    cpu_rdata  = '0;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    unique case (state_q)
      StIdle: begin
        if (!flush && !cpu_wr_en && cpu_rd_en && hit) begin
          cpu_ready = 1'b1;
          cpu_rdata = hit_word;
        end
      end
      StFill: begin
        mem_rd_req = 1'b1;
        mem_addr   = line_addr;
        if (mem_ready) begin
          cpu_ready = 1'b1;
          cpu_rdata = fill_words[woff];
        end
      end
      StWthru: begin
        mem_wr_req = 1'b1;
        mem_addr   = cpu_addr;
        mem_wdata  = cpu_wdata;
        cpu_ready  = mem_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      lru_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (flush) begin
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            lru_q      <= '0;
          end else if (cpu_wr_en) begin
            if (hit) lru_q[set_idx] <= hit_way;
            state_q <= StWthru;
          end else if (cpu_rd_en) begin
            if (hit) begin
              lru_q[set_idx] <= hit_way;
              if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            end else begin
              if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
              state_q <= StFill;
            end
          end
        end
        StFill: begin
          if (mem_ready) begin
            valid_q[victim][set_idx] <= 1'b1;
            tag_q[victim][set_idx]   <= tag;
            lru_q[set_idx]           <= victim;
            state_q                  <= StIdle;
          end
        end
        StWthru: begin
          if (mem_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Line data needs no reset: it is only observable through a set valid bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        if (fill_done) begin
          data_q[victim][set_idx][i] <= fill_words[i];
        end else if (wr_hit && (woff == WOFF_W'(i))) begin
          data_q[hit_way][set_idx][i] <= cpu_wdata;
        end
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_set_assoc_cache.sv
// Scoreboard bench for set_assoc_cache: memory and cache contents are modelled as
// per-set LRU lists of resident line numbers over a word-addressed memory image.
module tb_set_assoc_cache;

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SET_BITS = 6;
  localparam int unsigned LINE_WORDS = 2;
  localparam int unsigned NSETS = 64;

  logic clk = 1'b0;
  logic rst;
  logic cpu_rd_en, cpu_wr_en, flush, mem_ready;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata, mem_wdata;
  logic cpu_ready, mem_rd_req, mem_wr_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W*LINE_WORDS-1:0] mem_rdata;
  logic [15:0] hit_cnt, miss_cnt;

  set_assoc_cache #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SET_BITS(SET_BITS), .LINE_WORDS(LINE_WORDS)
  ) dut (
    .clk(clk), .rst(rst), .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .flush(flush), .mem_rd_req(mem_rd_req),
    .mem_wr_req(mem_wr_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic        is_wr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_m [int unsigned];
  int unsigned m_line [NSETS][2];  // index 0 = most recently used
  int          m_nv [NSETS];
  int unsigned m_hits, m_misses;

  function automatic logic [31:0] mem_word(input int unsigned w);
    if (mem_m.exists(w)) return mem_m[w];
    return (w * 32'h9E3779B9) ^ 32'hC3A50F1E;
  endfunction

  function automatic bit m_lookup(input int unsigned line);
    int unsigned s = line % NSETS;
    for (int i = 0; i < m_nv[s]; i++) if (m_line[s][i] == line) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_touch(input int unsigned line);
    int unsigned s = line % NSETS;
    if (m_nv[s] == 2 && m_line[s][1] == line) begin
      m_line[s][1] = m_line[s][0];
      m_line[s][0] = line;
    end
  endfunction

  function automatic void m_insert(input int unsigned line);
    int unsigned s = line % NSETS;
    m_line[s][1] = m_line[s][0];
    m_line[s][0] = line;
    if (m_nv[s] < 2) m_nv[s]++;
  endfunction

  function automatic void m_clear();
    for (int s = 0; s < NSETS; s++) m_nv[s] = 0;
  endfunction

  // ---------------- monitor ----------------
  bit          burst = 1'b0;
  logic [31:0] burst_data;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (!rst && cpu_ready) begin
      if (burst) begin
        check("burst_rdata", cpu_rdata, burst_data);
      end else if (exp_q.size() == 0) begin
        check("unexpected_ready", 32'(cpu_ready), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("ready_kind", 32'(cpu_wr_en), 32'(mon_e.is_wr));
        if (!mon_e.is_wr) check("rdata", cpu_rdata, mon_e.data);
      end
    end
  end

  // ---------------- driver ----------------
  logic              obs_hit;
  logic [31:0]       obs_rdata, obs_mem_wdata;
  logic [ADDR_W-1:0] obs_mem_addr;

  task automatic access(input bit wr, input bit rd_too, input logic [ADDR_W-1:0] addr,
                        input logic [31:0] wdata, input int lat, input bit flush_mid);
    int unsigned line, word, base;
    bit hit;
    exp_t e;
    line = 32'(addr) >> 3;
    word = 32'(addr) >> 2;
    base = line * 2;
    hit  = m_lookup(line);
    e.is_wr = wr;
    e.data  = '0;
    if (wr) begin
      mem_m[word] = wdata;
      if (hit) m_touch(line);
    end else begin
      e.data = mem_word(word);
      if (hit) begin
        m_touch(line);
        if (m_hits != 65535) m_hits++;
      end else begin
        m_insert(line);
        if (m_misses != 65535) m_misses++;
      end
    end
    exp_q.push_back(e);
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_wr_en = wr;
    cpu_rd_en = !wr || rd_too;
    @(negedge clk);
    obs_hit = cpu_ready;
    if (wr) check("wr_idle_not_ready", 32'(cpu_ready), 32'd0);
    else    check("read_hit_same_cycle", 32'(cpu_ready), 32'(hit));
    if (cpu_ready) begin
      obs_rdata = cpu_rdata;
      @(posedge clk); #1;
      cpu_rd_en = 1'b0;
      cpu_wr_en = 1'b0;
      return;
    end
    @(posedge clk); #1;
    for (int c = 0; c <= lat; c++) begin
      if (c == lat) begin
        mem_ready = 1'b1;
        mem_rdata = {mem_word(base + 1), mem_word(base)};
      end
      if (flush_mid && c == 0) flush = 1'b1;
      @(negedge clk);
      if (c == 0) begin
        obs_mem_addr  = mem_addr;
        obs_mem_wdata = mem_wdata;
        if (wr) begin
          check("wthru_req", 32'(mem_wr_req), 32'd1);
          check("wthru_no_rd", 32'(mem_rd_req), 32'd0);
          check("wthru_addr", 32'(mem_addr), 32'(addr));
          check("wthru_wdata", mem_wdata, wdata);
        end else begin
          check("fill_req", 32'(mem_rd_req), 32'd1);
          check("fill_no_wr", 32'(mem_wr_req), 32'd0);
          check("fill_addr", 32'(mem_addr), 32'(addr & 18'h3FFF8));
        end
      end
      if (c < lat) begin
        check("wait_not_ready", 32'(cpu_ready), 32'd0);
      end else begin
        check("done_ready", 32'(cpu_ready), 32'd1);
        obs_rdata = cpu_rdata;
      end
      @(posedge clk); #1;
      mem_ready = 1'b0;
      flush     = 1'b0;
    end
    cpu_rd_en = 1'b0;
    cpu_wr_en = 1'b0;
  endtask

  task automatic flush_idle(input logic [ADDR_W-1:0] addr);
    cpu_addr  = addr;
    cpu_rd_en = 1'b1;
    flush     = 1'b1;
    @(negedge clk);
    check("flush_blocks_ready", 32'(cpu_ready), 32'd0);
    check("flush_no_req", 32'({mem_rd_req, mem_wr_req}), 32'd0);
    @(posedge clk); #1;
    flush     = 1'b0;
    cpu_rd_en = 1'b0;
    m_clear();
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = {$urandom, $urandom};
      @(negedge clk);
      check("idle_quiet", 32'({cpu_ready, mem_rd_req, mem_wr_req}), 32'd0);
      @(posedge clk); #1;
      mem_ready = 1'b0;
    end
  endtask

  task automatic check_counters();
    check("hit_cnt", 32'(hit_cnt), m_hits);
    check("miss_cnt", 32'(miss_cnt), m_misses);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cpu_rd_en = 1'b0;
    cpu_wr_en = 1'b0;
    flush = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_clear();
    m_hits = 0;
    m_misses = 0;
    exp_q.delete();
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [ADDR_W-1:0] a;
    int unsigned op;
    rst = 1'b1; cpu_rd_en = 1'b0; cpu_wr_en = 1'b0; flush = 1'b0; mem_ready = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; mem_rdata = '0;
    m_clear(); m_hits = 0; m_misses = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_ready", 32'(cpu_ready), 32'd0);
    check("rst_reqs", 32'({mem_rd_req, mem_wr_req}), 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_cnts", {hit_cnt, miss_cnt}, 32'd0);
    @(posedge clk); #1;

    // cold read miss then same-cycle hit
    mem_m[32'h40] = 32'hAAAAAAAA;
    mem_m[32'h41] = 32'hBBBBBBBB;
    access(0, 0, 18'h00104, 0, 3, 0);
    check("s1_miss", 32'(obs_hit), 32'd0);
    check("s1_mem_addr", 32'(obs_mem_addr), 32'h00100);
    check("s1_rdata", obs_rdata, 32'hBBBBBBBB);
    check("s1_miss_cnt", 32'(miss_cnt), 32'd1);
    access(0, 0, 18'h00104, 0, 0, 0);
    check("s1_hit", 32'(obs_hit), 32'd1);
    check("s1_hit_rdata", obs_rdata, 32'hBBBBBBBB);
    check("s1_hit_cnt", 32'(hit_cnt), 32'd1);

    // LRU eviction in set 0
    access(0, 0, 18'h00200, 0, 1, 0);
    access(0, 0, 18'h00400, 0, 1, 0);
    access(0, 0, 18'h00200, 0, 0, 0);
    check("s2_tag1_hit", 32'(obs_hit), 32'd1);
    access(0, 0, 18'h00600, 0, 2, 0);
    check("s2_tag3_miss", 32'(obs_hit), 32'd0);
    access(0, 0, 18'h00200, 0, 0, 0);
    check("s2_tag1_still_hits", 32'(obs_hit), 32'd1);
    access(0, 0, 18'h00400, 0, 1, 0);
    check("s2_tag2_evicted", 32'(obs_hit), 32'd0);

    // write-through, no write-allocate, write beats read
    access(1, 0, 18'h00104, 32'h12345678, 2, 0);
    check("s3_wthru_wdata", obs_mem_wdata, 32'h12345678);
    check("s3_wthru_addr", 32'(obs_mem_addr), 32'h00104);
    access(0, 0, 18'h00104, 0, 0, 0);
    check("s3_wr_hit_read", 32'(obs_hit), 32'd1);
    check("s3_wr_hit_data", obs_rdata, 32'h12345678);
    access(1, 0, 18'h00808, 32'hCAFEF00D, 1, 0);
    access(0, 0, 18'h00808, 0, 1, 0);
    check("s3_no_alloc_miss", 32'(obs_hit), 32'd0);
    check("s3_no_alloc_data", obs_rdata, 32'hCAFEF00D);
    access(1, 1, 18'h00104, 32'h0BADBEEF, 0, 0);
    access(0, 0, 18'h00104, 0, 0, 0);
    check("s3_write_wins", obs_rdata, 32'h0BADBEEF);
    check_counters();

    // flush in IDLE, then flush ignored during FILL
    flush_idle(18'h00104);
    access(0, 0, 18'h00104, 0, 0, 0);
    check("s4_flushed_miss_a", 32'(obs_hit), 32'd0);
    access(0, 0, 18'h00200, 0, 0, 0);
    check("s4_flushed_miss_b", 32'(obs_hit), 32'd0);
    access(0, 0, 18'h01000, 0, 2, 1);
    access(0, 0, 18'h01000, 0, 0, 0);
    check("s4_flush_in_fill_ignored", 32'(obs_hit), 32'd1);
    check_counters();

    // reset during FILL abandons the refill
    cpu_addr = 18'h00A00;
    cpu_rd_en = 1'b1;
    @(negedge clk);
    check("s5_idle_miss", 32'(cpu_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("s5_fill_req", 32'(mem_rd_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = {32'h11111111, 32'h22222222};
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ready = 1'b0;
    cpu_rd_en = 1'b0;
    m_clear(); m_hits = 0; m_misses = 0;
    @(negedge clk);
    check("s5_req_dropped", 32'(mem_rd_req), 32'd0);
    check("s5_cnts_zero", {hit_cnt, miss_cnt}, 32'd0);
    @(posedge clk); #1;
    access(0, 0, 18'h00A00, 0, 0, 0);
    check("s5_not_installed", 32'(obs_hit), 32'd0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 39);
      a = ADDR_W'(($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 3) |
                  ($urandom_range(0, 1) << 2) | $urandom_range(0, 3));
      if (op == 0) flush_idle(a);
      else if (op < 26) access(0, 0, a, 0, $urandom_range(0, 3), 0);
      else if (op < 38) access(1, $urandom_range(0, 1), a, $urandom, $urandom_range(0, 3), 0);
      else idle_gap($urandom_range(1, 3));
      check_counters();
    end

    // hit counter saturation
    do_reset();
    access(0, 0, 18'h00104, 0, 0, 0);
    burst_data = mem_word(32'h41);
    cpu_addr = 18'h00104;
    cpu_rd_en = 1'b1;
    burst = 1'b1;
    repeat (65540) @(posedge clk);
    #1 cpu_rd_en = 1'b0;
    @(negedge clk);
    burst = 1'b0;
    check("sat_hit_cnt", 32'(hit_cnt), 32'h0000FFFF);
    check("sat_miss_cnt", 32'(miss_cnt), 32'd1);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/set_assoc_cache.md
SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 18, meaning the byte-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the word width.
REQ-003 The block SHALL have parameter SET_BITS, default 6, meaning log2 of the number of sets.
REQ-004 The block SHALL have parameter LINE_WORDS, default 2, meaning words per line, a power of two >= 1.
REQ-005 The block SHALL use one clock and a reset that is synchronous and active-high; ports are clk and rst.
REQ-006 Port list (name  direction  width  meaning), in this order:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cpu_rd_en  in  1  read request, held until cpu_ready.
- cpu_wr_en  in  1  write request, held until cpu_ready.
- cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- cpu_wdata  in  DATA_W  write data.
- cpu_rdata  out  DATA_W  read data, valid while cpu_ready=1 on a read.
- cpu_ready  out  1  request complete.
- flush  in  1  invalidate-all pulse.
- mem_rd_req  out  1  line read request, held until mem_ready.
- mem_wr_req  out  1  word write request, held until mem_ready.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  write-through data.
- mem_rdata  in  DATA_W*LINE_WORDS  refill line, word 0 in the LSBs.
- mem_ready  in  1  memory transfer done.
- hit_cnt  out  16  read-hit count.
- miss_cnt  out  16  read-miss count.

Function
REQ-007 Address split SHALL be: [1:0] byte; then WOFF = log2(LINE_WORDS) word-offset bits; then SET_BITS index bits; tag = the remaining upper bits.
REQ-008 Storage SHALL be 2 ways per set; each entry holds a valid bit, a tag and LINE_WORDS data words, plus one LRU bit per set.
REQ-009 The LRU bit SHALL have these values: lru=1 means way0 is the victim; lru=0 means way1 is the victim.
REQ-010 A read or write hit in way0 SHALL set lru=0; a hit in way1 SHALL set lru=1.
REQ-011 A way SHALL hit when its valid bit is set and its stored tag equals the address tag; both ways hitting cannot occur by construction.
REQ-012 The FSM SHALL have three states: IDLE, FILL and WTHRU.
REQ-013 IDLE, read hit: cpu_ready=1 and cpu_rdata = the hit word, combinationally in the same cycle; the LRU updates at the edge; the state stays IDLE.
REQ-014 IDLE, read miss: cpu_ready=0; the next state is FILL.
REQ-015 FILL: mem_rd_req=1 and mem_addr = cpu_addr with its word-offset and byte bits zeroed.
REQ-016 FILL, on mem_ready=1, the following SHALL happen:
- the line is installed in the victim way with valid=1 and the new tag;
- the LRU points away from the installed way;
- cpu_ready=1 and cpu_rdata = the selected word of mem_rdata, in that same cycle;
- the next state is IDLE.
REQ-017 The victim SHALL be chosen as follows: way0 if invalid, else way1 if invalid, else the way named by the LRU bit.
REQ-018 Writes SHALL be write-through with no write-allocate.
REQ-019 IDLE, cpu_wr_en=1: on a hit, the addressed word of the hit way is updated and the LRU updated at the edge; on a miss, the cache is unchanged; the next state is WTHRU in both cases.
REQ-020 WTHRU: mem_wr_req=1, mem_addr = cpu_addr and mem_wdata = cpu_wdata; on mem_ready, cpu_ready=1 and the next state is IDLE.
REQ-021 If cpu_rd_en and cpu_wr_en are both 1 in IDLE, the write SHALL win.
REQ-022 The memory request SHALL NOT be dropped while waiting; mem_ready outside FILL/WTHRU SHALL be ignored.
REQ-023 flush=1 in IDLE SHALL clear all valid and LRU bits at the edge, take priority over any CPU request that cycle (cpu_ready=0), and leave the state in IDLE.
REQ-024 flush in FILL or WTHRU SHALL be ignored.
REQ-025 hit_cnt SHALL increment on each IDLE read hit, and miss_cnt on each IDLE-to-FILL transition; both saturate at 16'hFFFF; write hits are not counted.
REQ-026 cpu_ready, mem_rd_req and mem_wr_req SHALL be 0 in every cycle and state not listed above.

Reset
REQ-027 While rst=1 at a clock edge, the block SHALL:
- clear all valid bits and all LRU bits;
- set the FSM to IDLE;
- set hit_cnt and miss_cnt to 0.
REQ-028 After reset, cpu_ready=0, mem_rd_req=0 and mem_wr_req=0; cpu_rdata, mem_addr and mem_wdata SHALL read 0 while no request is active.
REQ-029 Reset SHALL take effect in any state, including mid-FILL and mid-WTHRU, and abandon any outstanding request without installing its line.

Verification
REQ-030 The bench SHALL cover these directed scenarios (defaults):
- Cold read 0x00104, mem_ready after 3 cycles with mem_rdata=0xBBBB_BBBB_AAAA_AAAA -> mem_addr=0x00100, cpu_rdata=0xBBBBBBBB, miss_cnt=1; a repeat read gives a same-cycle hit and hit_cnt=1.
- Fill set 0 with tags 1 and 2, read tag 1, then miss on tag 3 -> tag 2's way is evicted and tag 1 still hits.
- Write 0x12345678 to a resident address -> WTHRU with mem_wdata=0x12345678, a later read hits with 0x12345678; a write to a non-resident address leaves a later read as a miss.
- Flush in IDLE after fills -> every prior address misses; flush asserted during FILL -> ignored and the line is installed.
- rst asserted during FILL -> mem_rd_req=0 next cycle, the line is not installed and the counters are 0.
- 65536 read hits -> hit_cnt saturates at 0xFFFF.
